// File: rtl/icache_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : icache_fetch_if
// Description : Fetch-stage bundle: pipeline control, IF/ID outputs, refill bus.
// Revision    : 1.0
//------------------------------------------------------------------------------
interface icache_fetch_if;
    logic        STALL;
    logic        BRANCH;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        HIT;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_DATA;
    logic        MEM_VALID;

    modport master (
        input  STALL, BRANCH, BRANCH_TARGET, MEM_DATA, MEM_VALID,
        output PC, INSTRUCTION, HIT, MEM_REQ, MEM_ADDR
    );

    modport slave (
        output STALL, BRANCH, BRANCH_TARGET, MEM_DATA, MEM_VALID,
        input  PC, INSTRUCTION, HIT, MEM_REQ, MEM_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : icache_fetch
// Description : PC owner with direct-mapped I-cache and word-serial refill.
// Revision    : 1.0
//------------------------------------------------------------------------------
module icache_fetch #(
    parameter int          LINES    = 16,
    parameter int          WORDS    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    icache_fetch_if.master bus
);
    localparam int c_WW = $clog2(WORDS);
    localparam int c_LW = $clog2(LINES);
    localparam int c_OB = 2 + c_WW;
    localparam int c_TB = c_OB + c_LW;
    localparam int c_TW = 32 - c_TB;
    localparam logic [c_WW-1:0] c_LAST = c_WW'(WORDS - 1);

    typedef enum logic [0:0] {
        S_LOOKUP = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_pend_target;
    logic             r_pend;
    logic             r_mem_req;
    logic [c_WW-1:0]  r_cnt;
    logic [LINES-1:0] r_valid;
    logic [c_TW-1:0]  r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];

    logic [c_WW-1:0]  w_word;
    logic [c_LW-1:0]  w_idx;
    logic [c_TW-1:0]  w_tag;
    logic [31:0]      w_target;
    logic [31:0]      w_line_base;
    logic             w_resident;
    logic             w_beat;
    logic             w_last;

    assign w_word      = r_pc[c_OB-1:2];
    assign w_idx       = r_pc[c_TB-1:c_OB];
    assign w_tag       = r_pc[31:c_TB];
    assign w_target    = bus.BRANCH_TARGET & 32'hFFFF_FFFC;
    assign w_line_base = {r_pc[31:c_OB], {c_OB{1'b0}}};
    assign w_resident  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat      = (r_state == S_REFILL) && bus.MEM_VALID;
    assign w_last      = w_beat && (r_cnt == c_LAST);

    assign bus.PC          = r_pc;
    assign bus.HIT         = (r_state == S_LOOKUP) && w_resident;
    assign bus.INSTRUCTION = r_data[w_idx][w_word];
    assign bus.MEM_REQ     = r_mem_req;
    assign bus.MEM_ADDR    = r_mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_LOOKUP;
            r_pc          <= RESET_PC;
            r_mem_addr    <= '0;
            r_pend_target <= '0;
            r_pend        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_cnt         <= '0;
            r_valid       <= '0;
        end else begin
            case (r_state)
                S_LOOKUP: begin
                    if (bus.BRANCH) begin
                        r_pc <= w_target;
                    end else if (w_resident) begin
                        if (!bus.STALL) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end else begin
                        r_state    <= S_REFILL;
                        r_cnt      <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_line_base;
                    end
                end
                S_REFILL: begin
                    // Redirects are parked until the line is complete; newest wins.
                    if (bus.BRANCH) begin
                        r_pend        <= 1'b1;
                        r_pend_target <= w_target;
                    end
                    if (w_beat) begin
                        if (r_cnt == c_LAST) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= S_LOOKUP;
                            r_mem_req      <= 1'b0;
                            r_cnt          <= '0;
                            if (bus.BRANCH) begin
                                r_pc   <= w_target;
                                r_pend <= 1'b0;
                            end else if (r_pend) begin
                                r_pc   <= r_pend_target;
                                r_pend <= 1'b0;
                            end
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                default: r_state <= S_LOOKUP;
            endcase
        end
    end

    // Arrays carry no reset; only the valid bits decide residency.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[w_idx][r_cnt] <= bus.MEM_DATA;
        end
        if (w_last) begin
            r_tag[w_idx] <= w_tag;
        end
    end
endmodule
`default_nettype wire

// File: doc/icache_fetch.md
# icache_fetch

Instruction-fetch front end with a direct-mapped instruction cache. It owns the program counter, looks each PC up in the cache, and presents PC, INSTRUCTION and HIT to the IF/ID pipeline register. IF/ID captures only when HIT is high. On a miss it refills the line from main memory with a simple word-serial handshake. Branch redirects and pipeline stalls enter here from the ID/EX stages.

## Interface
- LINES, 16, number of cache lines; power of two, at least 2
- WORDS, 4, 32-bit words per line; power of two, at least 2
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- STALL  in  1  hold PC; refill still progresses
- BRANCH  in  1  redirect request, one-cycle pulse
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored
- PC  out  32  current fetch address, registered
- INSTRUCTION  out  32  cached word at PC; meaningful only when HIT=1
- HIT  out  1  PC's line is resident and state is LOOKUP
- MEM_REQ  out  1  refill in progress, registered
- MEM_ADDR  out  32  word address being requested
- MEM_DATA  in  32  refill word
- MEM_VALID  in  1  MEM_DATA valid for MEM_ADDR this cycle

## Operation
- Address split: [1:0] byte offset, ignored. Next log2(WORDS) bits are the word index. Next log2(LINES) bits are the line index. The remaining upper bits are the tag.
- Storage: a data array of LINES×WORDS words, plus one tag and one valid bit per line.
- States:
  - LOOKUP: HIT = valid[idx] & (tag[idx]==PC tag). INSTRUCTION = data[idx][word].
  - REFILL: HIT=0. MEM_REQ=1. MEM_ADDR = {PC line-aligned, cnt, 2'b00}.
- LOOKUP transitions:
  - BRANCH=1: PC <= {BRANCH_TARGET[31:2],2'b00}. Stay in LOOKUP. No refill starts, even if the current PC misses. BRANCH has priority over STALL.
  - Else hit and !STALL: PC <= PC+4. Arithmetic is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Else hit and STALL: PC holds.
  - Else miss: go to REFILL with cnt=0. PC holds.
- REFILL transitions:
  - Each MEM_VALID writes MEM_DATA into data[idx][cnt], then cnt increments.
  - When cnt==WORDS-1 with MEM_VALID: set tag[idx] and valid[idx]=1, clear MEM_REQ, return to LOOKUP.
- Refill is never aborted. A BRANCH during REFILL is latched into a pending-redirect register (target plus flag); a later BRANCH overwrites an earlier one. When the state returns to LOOKUP, PC is loaded from the pending target and the flag is cleared. That lookup then proceeds normally.
- STALL during REFILL has no effect. After the refill, PC stays at the missed address.
- Reset (async, any state): PC=RESET_PC. All valid bits=0. State=LOOKUP. cnt=0. MEM_REQ=0. MEM_ADDR=0. Pending flag=0. HIT=0 because the arrays are invalid. Data and tag arrays are not cleared. Reset mid-refill discards the partial line, and the line stays invalid.

## Timing
- A hit delivers one instruction per cycle. PC updates on the posedge after HIT is sampled.
- Miss penalty: 1 detect cycle, then WORDS MEM_VALID beats (any number of gap cycles allowed), then 1 cycle to LOOKUP. HIT rises in the first LOOKUP cycle. Minimum miss-to-hit is WORDS+1 cycles.
- MEM_ADDR is stable while MEM_VALID is low. It advances by 4 on the cycle after each accepted beat.
- MEM_VALID outside REFILL is ignored.
- HIT and INSTRUCTION are combinational from registered PC and array state, so they settle before the IF/ID capture edge.

## Test plan
- Reset with RESET_PC=32'h100, memory holding word N at address 4N. Expected: miss, then MEM_ADDR sequence 0x100, 0x104, 0x108, 0x10C. HIT rises with PC=0x100 and INSTRUCTION=0x40. HIT stays high through PC=0x10C, then a miss at 0x110.
- Re-execute the line at 0x100 after a branch with BRANCH_TARGET=0x100. Expected: HIT in the first cycle after the redirect, and MEM_REQ never asserts.
- BRANCH to 0x200 on the second beat of a refill of 0x110. Expected: all 4 beats complete, valid set for the 0x110 line, then PC=0x200 and a new miss.
- Conflict: fetch 0x000, then branch to 0x100 with LINES=16, WORDS=4 (same index 0). Expected: the 0x100 refill evicts the line, and a later fetch of 0x000 misses again.
- Pulse rst_n low mid-refill after 2 beats. Expected: MEM_REQ=0 immediately, PC=RESET_PC, the line stays invalid, and a full 4-beat refill follows.
- STALL high for 3 cycles during hits at PC=0x104. Expected: PC holds at 0x104 with HIT=1, then advances to 0x108 when STALL is released.
